// File: rtl/fixed_dot_product_accumulator_pkg.sv
// Shared types for the dot-product accumulator: debug view of the implicit
// ACCUM/EMIT state machine and the count-width helper.
package fixed_dot_product_accumulator_pkg;

  typedef enum logic {
    PH_ACCUM = 1'b0,
    PH_EMIT  = 1'b1
  } phase_e;

  typedef struct packed {
    phase_e      phase;
    logic [15:0] count;
  } acc_dbg_t;

  // count needs at least one bit even when only a single beat forms a result
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fixed_dot_product_accumulator_if.sv
// Input and output streams of the dot-product accumulator in one bundle.
// Handshake rule for both streams: a beat transfers on a rising edge where
// valid and ready are both high; valid never waits on ready.
interface fixed_dot_product_accumulator_if #(
  parameter int IN_WIDTH  = 50,
  parameter int OUT_WIDTH = 52
);
  logic [IN_WIDTH-1:0]  data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/fixed_dot_product_accumulator.sv
// Sums IN_DEPTH consecutive signed partial sums into one full-length dot
// product, with a single registered result slot and no bubble between groups.
module fixed_dot_product_accumulator
  import fixed_dot_product_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 50,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_WIDTH = IN_WIDTH + $clog2(IN_DEPTH)
) (
  input  logic clk,
  input  logic rst,
  fixed_dot_product_accumulator_if.slave bus,
  output acc_dbg_t dbg
);

  localparam int            CW   = cnt_width(IN_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(IN_DEPTH - 1);

  logic [CW-1:0]               count_q, count_d;
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] out_q, out_d;
  logic                        valid_q, valid_d;
  logic signed [OUT_WIDTH-1:0] ext, sum;
  logic                        ready, in_fire, out_fire;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  // Next state
  always_comb begin
    count_d  = count_q;
    acc_d    = acc_q;
    out_d    = out_q;
    valid_d  = valid_q;
    in_fire  = bus.data_in_valid & ready;
    out_fire = valid_q & bus.data_out_ready;
    // sign-extend (or wrap, if OUT_WIDTH is overridden narrower)
    ext      = OUT_WIDTH'($signed(bus.data_in));
    sum      = (count_q == '0) ? ext : acc_q + ext;

    // clear first so a final beat in the same cycle can re-arm the slot
    if (out_fire) valid_d = 1'b0;

    if (in_fire) begin
      if (count_q == LAST) begin
        out_d   = sum;
        valid_d = 1'b1;
        count_d = '0;
        acc_d   = '0;
      end else begin
        acc_d   = sum;
        count_d = count_q + CW'(1);
      end
    end
  end

  // Outputs
  always_comb begin
    ready              = !valid_q | bus.data_out_ready;
    bus.data_in_ready  = ready;
    bus.data_out       = out_q;
    bus.data_out_valid = valid_q;
    dbg.phase          = valid_q ? PH_EMIT : PH_ACCUM;
    dbg.count          = 16'(count_q);
  end

endmodule

// File: tb/tb_fixed_dot_product_accumulator.sv
// Directed bench for the dot-product accumulator: 50-bit/depth-4, 8-bit/depth-4
// and 16-bit/depth-1 instances sharing one clock and reset.
module tb_fixed_dot_product_accumulator;
  import fixed_dot_product_accumulator_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fixed_dot_product_accumulator_if #(.IN_WIDTH(50), .OUT_WIDTH(52)) bus4 ();
  fixed_dot_product_accumulator_if #(.IN_WIDTH(8),  .OUT_WIDTH(10)) bus8 ();
  fixed_dot_product_accumulator_if #(.IN_WIDTH(16), .OUT_WIDTH(16)) bus1 ();
  acc_dbg_t dbg4, dbg8, dbg1;

  fixed_dot_product_accumulator #(.IN_WIDTH(50), .IN_DEPTH(4)) u_acc4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg(dbg4));
  fixed_dot_product_accumulator #(.IN_WIDTH(8), .IN_DEPTH(4)) u_acc8 (
    .clk(clk), .rst(rst), .bus(bus8), .dbg(dbg8));
  fixed_dot_product_accumulator #(.IN_WIDTH(16), .IN_DEPTH(1)) u_acc1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg(dbg1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  // drivers: change inputs on the falling edge, settle, then the caller samples
  task automatic drive4(input logic v, input longint d, input logic rdy);
    @(negedge clk);
    bus4.data_in_valid  = v;
    bus4.data_in        = 50'(d);
    bus4.data_out_ready = rdy;
    #1;
  endtask

  task automatic drive8(input logic v, input longint d, input logic rdy);
    @(negedge clk);
    bus8.data_in_valid  = v;
    bus8.data_in        = 8'(d);
    bus8.data_out_ready = rdy;
    #1;
  endtask

  task automatic drive1(input logic v, input longint d, input logic rdy);
    @(negedge clk);
    bus1.data_in_valid  = v;
    bus1.data_in        = 16'(d);
    bus1.data_out_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus4.data_in_valid = 1'b0; bus4.data_in = '0; bus4.data_out_ready = 1'b1;
    bus8.data_in_valid = 1'b0; bus8.data_in = '0; bus8.data_out_ready = 1'b1;
    bus1.data_in_valid = 1'b0; bus1.data_in = '0; bus1.data_out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus4.data_out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b exp 0", bus4.data_out_valid);
    end
    total++;
    if (bus4.data_out !== 52'd0) begin
      bad++; $display("FAIL reset_data: got %0d exp 0", $signed(bus4.data_out));
    end
    total++;
    if (bus4.data_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b exp 1", bus4.data_in_ready);
    end
    total++;
    if (dbg4.count !== 16'd0 || dbg4.phase !== PH_ACCUM) begin
      bad++; $display("FAIL reset_state: got count %0d phase %0d exp 0/0", dbg4.count, dbg4.phase);
    end
  endtask

  task automatic test_basic();
    longint vals[4] = '{10, -3, 7, 1};
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, vals[i], 1'b1);
      total++;
      if (bus4.data_in_ready !== 1'b1) begin
        bad++; $display("FAIL basic_ready beat %0d: got %b exp 1", i, bus4.data_in_ready);
      end
    end
    drive4(1'b0, 0, 1'b1);
    total++;
    if (bus4.data_out_valid !== 1'b1 || bus4.data_out !== 52'd15) begin
      bad++; $display("FAIL basic_result: got v=%b %0d exp v=1 15", bus4.data_out_valid, $signed(bus4.data_out));
    end
    drive4(1'b0, 0, 1'b1);
    total++;
    if (bus4.data_out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_one_cycle: got v=%b exp 0", bus4.data_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      drive4(1'b1, k + 1, 1'b1);
      total++;
      if (bus4.data_in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_ready beat %0d: got %b exp 1", k, bus4.data_in_ready);
      end
      total++;
      if (bus4.data_out_valid !== (k == 4)) begin
        bad++; $display("FAIL stream_valid beat %0d: got %b exp %b", k, bus4.data_out_valid, (k == 4));
      end
      if (k == 4) begin
        total++;
        if (bus4.data_out !== 52'd10) begin
          bad++; $display("FAIL stream_first: got %0d exp 10", $signed(bus4.data_out));
        end
      end
    end
    drive4(1'b0, 0, 1'b1);
    total++;
    if (bus4.data_out_valid !== 1'b1 || bus4.data_out !== 52'd26) begin
      bad++; $display("FAIL stream_second: got v=%b %0d exp v=1 26", bus4.data_out_valid, $signed(bus4.data_out));
    end
    drive4(1'b0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 2, 1'b0);
      total++;
      if (bus4.data_in_ready !== 1'b1) begin
        bad++; $display("FAIL bp_fill_ready beat %0d: got %b exp 1", i, bus4.data_in_ready);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive4(1'b1, 100, 1'b0);
      total++;
      if (bus4.data_out_valid !== 1'b1 || bus4.data_out !== 52'd8) begin
        bad++; $display("FAIL bp_hold cycle %0d: got v=%b %0d exp v=1 8", i, bus4.data_out_valid, $signed(bus4.data_out));
      end
      total++;
      if (bus4.data_in_ready !== 1'b0 || dbg4.count !== 16'd0) begin
        bad++; $display("FAIL bp_block cycle %0d: got rdy=%b cnt=%0d exp rdy=0 cnt=0", i, bus4.data_in_ready, dbg4.count);
      end
    end
    drive4(1'b1, 1, 1'b1);
    total++;
    if (bus4.data_in_ready !== 1'b1 || bus4.data_out !== 52'd8) begin
      bad++; $display("FAIL bp_release: got rdy=%b %0d exp rdy=1 8", bus4.data_in_ready, $signed(bus4.data_out));
    end
    drive4(1'b1, 2, 1'b1);
    drive4(1'b1, 3, 1'b1);
    drive4(1'b1, 4, 1'b1);
    drive4(1'b0, 0, 1'b1);
    total++;
    if (bus4.data_out_valid !== 1'b1 || bus4.data_out !== 52'd10) begin
      bad++; $display("FAIL bp_next: got v=%b %0d exp v=1 10", bus4.data_out_valid, $signed(bus4.data_out));
    end
    drive4(1'b0, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    drive4(1'b1, 9, 1'b1);
    drive4(1'b1, 9, 1'b1);
    drive4(1'b0, 0, 1'b1);
    total++;
    if (dbg4.count !== 16'd2) begin
      bad++; $display("FAIL midrst_count: got %0d exp 2", dbg4.count);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (dbg4.count !== 16'd0 || bus4.data_out !== 52'd0) begin
      bad++; $display("FAIL midrst_clear: got cnt=%0d out=%0d exp 0/0", dbg4.count, $signed(bus4.data_out));
    end
    for (int i = 0; i < 4; i++) drive4(1'b1, 5, 1'b1);
    drive4(1'b0, 0, 1'b1);
    total++;
    if (bus4.data_out_valid !== 1'b1 || bus4.data_out !== 52'd20) begin
      bad++; $display("FAIL midrst_result: got v=%b %0d exp v=1 20", bus4.data_out_valid, $signed(bus4.data_out));
    end
    drive4(1'b0, 0, 1'b1);
  endtask

  task automatic test_sign_width();
    for (int k = 0; k < 8; k++) begin
      drive8(1'b1, (k < 4) ? -128 : 127, 1'b1);
      if (k == 4) begin
        total++;
        if (bus8.data_out_valid !== 1'b1 || bus8.data_out !== 10'h200) begin
          bad++; $display("FAIL width_neg: got v=%b %h exp v=1 200", bus8.data_out_valid, bus8.data_out);
        end
      end
    end
    drive8(1'b0, 0, 1'b1);
    total++;
    if (bus8.data_out_valid !== 1'b1 || bus8.data_out !== 10'd508) begin
      bad++; $display("FAIL width_pos: got v=%b %0d exp v=1 508", bus8.data_out_valid, bus8.data_out);
    end
    drive8(1'b0, 0, 1'b1);
  endtask

  task automatic test_depth_one();
    longint   vals[5] = '{3, -1, 32767, -32768, 0};
    logic [15:0] exps[4] = '{16'd3, 16'hFFFF, 16'h7FFF, 16'h8000};
    for (int i = 0; i < 5; i++) begin
      drive1(i < 4, vals[i], 1'b1);
      if (i > 0) begin
        total++;
        if (bus1.data_out_valid !== 1'b1 || bus1.data_out !== exps[i-1]) begin
          bad++; $display("FAIL depth1_pass %0d: got v=%b %h exp v=1 %h", i, bus1.data_out_valid, bus1.data_out, exps[i-1]);
        end
      end
    end
    drive1(1'b0, 0, 1'b1);
    total++;
    if (bus1.data_out_valid !== 1'b0) begin
      bad++; $display("FAIL depth1_drain: got v=%b exp 0", bus1.data_out_valid);
    end
    drive1(1'b1, 42, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive1(1'b1, 43, 1'b0);
      total++;
      if (bus1.data_out !== 16'd42 || bus1.data_in_ready !== 1'b0) begin
        bad++; $display("FAIL depth1_hold %0d: got %0d rdy=%b exp 42 rdy=0", i, bus1.data_out, bus1.data_in_ready);
      end
    end
    drive1(1'b1, 43, 1'b1);
    drive1(1'b0, 0, 1'b1);
    total++;
    if (bus1.data_out_valid !== 1'b1 || bus1.data_out !== 16'd43) begin
      bad++; $display("FAIL depth1_after_bp: got v=%b %0d exp v=1 43", bus1.data_out_valid, bus1.data_out);
    end
    drive1(1'b0, 0, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_sign_width();
    test_depth_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
